// File: rtl/stq_drain_if.sv
// Bus between the drain controller and the store-queue units / result consumer.
// master: drain controller side; slave: units plus consumer side.
interface stq_drain_if #(
    parameter int unsigned NUM_UNITs      = 4,
    parameter int unsigned UNIT_INIT_BIT  = 4,
    parameter int unsigned DATA_PRECISION = 32
);
    logic [NUM_UNITs-1:0]                unit_svc_ready;
    logic [NUM_UNITs-1:0]                unit_deliver;
    logic [NUM_UNITs*DATA_PRECISION-1:0] unit_do;
    logic [UNIT_INIT_BIT-1:0]            svc_idx;
    logic [UNIT_INIT_BIT-1:0]            svc_threshold_idx;
    logic                                rd_en;
    logic                                out_valid;
    logic [UNIT_INIT_BIT-1:0]            out_idx;
    logic [DATA_PRECISION-1:0]           out_value;
    logic                                out_ready;

    modport master (
        input  unit_svc_ready, unit_deliver, unit_do, out_ready,
        output svc_idx, svc_threshold_idx, rd_en, out_valid, out_idx, out_value
    );

    modport slave (
        output unit_svc_ready, unit_deliver, unit_do, out_ready,
        input  svc_idx, svc_threshold_idx, rd_en, out_valid, out_idx, out_value
    );
endinterface

// File: rtl/stq_drain_ctrl.sv
// Drains store-queue units one row group at a time and emits the cross-unit sum per pop.
// Optional STQ_DRAIN_CNT_EN adds a saturating drain_count of pops.
module stq_drain_ctrl #(
    parameter int unsigned NUM_UNITs      = 4,
    parameter int unsigned UNIT_INIT_BIT  = 4,
    parameter int unsigned DATA_PRECISION = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     global_en,
    input  logic                     start,
    input  logic                     flush,
    input  logic [UNIT_INIT_BIT-1:0] last_idx,
    output logic                     busy,
    output logic                     done,
`ifdef STQ_DRAIN_CNT_EN
    output logic [15:0]              drain_count,
`endif
    stq_drain_if.master              bus
);

    typedef enum logic [2:0] {StIdle, StWait, StDrain, StAdvance, StDone} state_e;

    state_e                    state_q, state_d;
    logic [UNIT_INIT_BIT-1:0]  svc_idx_q, svc_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [UNIT_INIT_BIT-1:0]  out_idx_q, out_idx_d;
    logic [DATA_PRECISION-1:0] out_value_q, out_value_d;

    logic                      any_deliver, all_ready, can_pop, rd_en;
    logic [DATA_PRECISION-1:0] sum;

    assign any_deliver = |bus.unit_deliver;
    assign all_ready   = &bus.unit_svc_ready;
    // Pop only when the output register is free or being drained this cycle.
    assign can_pop     = global_en & (~out_valid_q | bus.out_ready);

    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < NUM_UNITs; k++) begin
            sum = sum + bus.unit_do[k*DATA_PRECISION +: DATA_PRECISION];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            svc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            svc_idx_q   <= svc_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_value_q <= out_value_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        svc_idx_d = svc_idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (global_en && start) begin
                    state_d   = StWait;
                    svc_idx_d = '0;
                end
            end
            StWait: begin
                if (global_en && (all_ready || flush)) state_d = StDrain;
            end
            StDrain: begin
                if (can_pop && !any_deliver) state_d = StAdvance;
            end
            StAdvance: begin
                if (global_en) begin
                    if (svc_idx_q == last_idx) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StWait;
                        svc_idx_d = svc_idx_q + UNIT_INIT_BIT'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en       = (state_q == StDrain) && can_pop && any_deliver;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_value_d = out_value_q;
        if (rd_en) begin
            out_valid_d = 1'b1;
            out_idx_d   = svc_idx_q;
            out_value_d = sum;
        end else if (global_en && out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            out_value_d = '0;
        end
        busy = (state_q != StIdle) && (state_q != StDone);
        done = (state_q == StDone);
    end

    assign bus.svc_idx           = svc_idx_q;
    assign bus.svc_threshold_idx = svc_idx_q + UNIT_INIT_BIT'(1);
    assign bus.rd_en             = rd_en;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_idx           = out_idx_q;
    assign bus.out_value         = out_value_q;

`ifdef STQ_DRAIN_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        start_go;

    assign start_go = global_en && start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        cnt_d = cnt_q;
        if (start_go) begin
            cnt_d = '0;
        end else if (rd_en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drain_count = cnt_q;
`endif

endmodule
